// File: rtl/data_mem_ctrl.sv
// Load/store controller between execute and a word-wide synchronous data memory.
// Sub-word stores use read-modify-write; misaligned or illegal-width accesses are rejected.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | ready; classify and launch an accepted access
// RD_ISSUE | mem_re pulse is on the bus, memory word arrives next cycle
// LD_CAP   | capture memory word, select lane, extend into rdata
// RMW_CAP  | merge store lane into memory word, launch the write
// WR       | mem_we pulse is on the bus
// FIN      | done/err pulse; folded into the return to IDLE, never held
module data_mem_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        sign_mask,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, LD_CAP, RMW_CAP, WR} state_t;

    state_t            state_q, state_d;
    logic              lat_we_q, lat_we_d;
    logic [1:0]        lat_off_q, lat_off_d;
    logic [15:0]       lat_wdata_q, lat_wdata_d;
    logic [3:0]        lat_mask_q, lat_mask_d;
    logic              done_d, err_d, mem_re_d, mem_we_d;
    logic [31:0]       rdata_d, mem_wdata_d;
    logic [ADDR_W-1:0] mem_addr_d;

    logic        is_b, is_h, is_w, bad_acc;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext, merged;

    // High address bits alias by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    assign ready = (state_q == IDLE);

    assign is_b    = (sign_mask[2:0] == 3'b001);
    assign is_h    = (sign_mask[2:0] == 3'b011);
    assign is_w    = (sign_mask[2:0] == 3'b111);
    assign bad_acc = !(is_b || is_h || is_w) || (is_h && addr[0]) || (is_w && (addr[1:0] != 2'b00));

    assign byte_lane = mem_rdata[{lat_off_q, 3'b000} +: 8];
    assign half_lane = mem_rdata[{lat_off_q[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = mem_rdata;
        merged   = mem_rdata;
        if (lat_mask_q[2:0] == 3'b001) begin
            load_ext = {{24{lat_mask_q[3] & byte_lane[7]}}, byte_lane};
            merged[{lat_off_q, 3'b000} +: 8] = lat_wdata_q[7:0];
        end else if (lat_mask_q[2:0] == 3'b011) begin
            load_ext = {{16{lat_mask_q[3] & half_lane[15]}}, half_lane};
            merged[{lat_off_q[1], 4'b0000} +: 16] = lat_wdata_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        lat_we_d    = lat_we_q;
        lat_off_d   = lat_off_q;
        lat_wdata_d = lat_wdata_q;
        lat_mask_d  = lat_mask_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        rdata_d     = rdata;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        case (state_q)
            IDLE: begin
                if (req) begin
                    lat_we_d    = we;
                    lat_off_d   = addr[1:0];
                    lat_wdata_d = wdata[15:0];
                    lat_mask_d  = sign_mask;
                    if (bad_acc) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        mem_addr_d = addr[ADDR_W+1:2];
                        if (we && is_w) begin
                            mem_we_d    = 1'b1;
                            mem_wdata_d = wdata;
                            state_d     = WR;
                        end else begin
                            mem_re_d = 1'b1;
                            state_d  = RD_ISSUE;
                        end
                    end
                end
            end
            RD_ISSUE: state_d = lat_we_q ? RMW_CAP : LD_CAP;
            LD_CAP: begin
                rdata_d = load_ext;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            RMW_CAP: begin
                mem_wdata_d = merged;
                mem_we_d    = 1'b1;
                state_d     = WR;
            end
            WR: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lat_we_q    <= 1'b0;
            lat_off_q   <= 2'b00;
            lat_wdata_q <= 16'h0000;
            lat_mask_q  <= 4'h0;
            done        <= 1'b0;
            err         <= 1'b0;
            rdata       <= 32'h0;
            mem_addr    <= '0;
            mem_re      <= 1'b0;
            mem_we      <= 1'b0;
            mem_wdata   <= 32'h0;
        end else begin
            state_q     <= state_d;
            lat_we_q    <= lat_we_d;
            lat_off_q   <= lat_off_d;
            lat_wdata_q <= lat_wdata_d;
            lat_mask_q  <= lat_mask_d;
            done        <= done_d;
            err         <= err_d;
            rdata       <= rdata_d;
            mem_addr    <= mem_addr_d;
            mem_re      <= mem_re_d;
            mem_we      <= mem_we_d;
            mem_wdata   <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a small synchronous word memory model.
module tb_data_mem_ctrl;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req, we;
    logic [31:0]       addr, wdata;
    logic [3:0]        sign_mask;
    logic              ready, done, err;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re, mem_we;
    logic [31:0]       mem_wdata, mem_rdata;

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic        preset;

    int checks = 0;
    int failures = 0;
    int both_cnt = 0;
    int err_nodone_cnt = 0;

    int re_at, we_at, done_at, n_re, n_we, n_done;
    logic        err_at_done;
    logic [31:0] wd_at_we;
    logic [7:0]  done_bits, re_bits, rdy_bits;
    logic [31:0] rd_k3, rd_k6;

    data_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .sign_mask(sign_mask), .ready(ready), .done(done), .err(err), .rdata(rdata),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preset) mem[4] <= 32'h8765F0A1;
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_re && mem_we) both_cnt++;
        if (err && !done) err_nodone_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with ready=1; observes six cycles after the accept.
    task automatic do_acc(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
        req = 1'b1; we = w; addr = a; wdata = wd; sign_mask = m;
        @(posedge clk);
        #1 req = 1'b0;
        re_at = 0; we_at = 0; done_at = 0; n_re = 0; n_we = 0; n_done = 0;
        err_at_done = 1'b0; wd_at_we = 32'h0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (mem_re) begin n_re++; re_at = k; end
            if (mem_we) begin n_we++; we_at = k; wd_at_we = mem_wdata; end
            if (done) begin n_done++; done_at = k; err_at_done = err; end
        end
    endtask

    initial begin
        rst_n = 1'b0; preset = 1'b1;
        req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; sign_mask = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_re", 32'(mem_re), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_ready", 32'(ready), 1);
        rst_n = 1'b1;
        @(negedge clk);
        preset = 1'b0;

        do_acc(1'b0, 32'h13, 32'h0, 4'b1001);
        chk("lb13_rdata", rdata, 32'hFFFFFF87);
        chk("lb13_done_at", done_at, 3);
        chk("lb13_re_at", re_at, 1);
        chk("lb13_n_re", n_re, 1);
        chk("lb13_n_we", n_we, 0);
        chk("lb13_err", 32'(err_at_done), 0);
        chk("lb13_mem_addr", 32'(mem_addr), 4);

        do_acc(1'b0, 32'h13, 32'h0, 4'b0001);
        chk("lbu13_rdata", rdata, 32'h00000087);
        do_acc(1'b0, 32'h10, 32'h0, 4'b1001);
        chk("lb10_rdata", rdata, 32'hFFFFFFA1);
        do_acc(1'b0, 32'h12, 32'h0, 4'b1011);
        chk("lh12_rdata", rdata, 32'hFFFF8765);
        do_acc(1'b0, 32'h10, 32'h0, 4'b0011);
        chk("lhu10_rdata", rdata, 32'h0000F0A1);
        do_acc(1'b0, 32'h10, 32'h0, 4'b1111);
        chk("lw10_rdata", rdata, 32'h8765F0A1);
        chk("lw10_done_at", done_at, 3);

        do_acc(1'b1, 32'h11, 32'h123456CC, 4'b1001);
        chk("sb11_re_at", re_at, 1);
        chk("sb11_we_at", we_at, 3);
        chk("sb11_n_we", n_we, 1);
        chk("sb11_wdata", wd_at_we, 32'h8765CCA1);
        chk("sb11_done_at", done_at, 4);
        chk("sb11_rdata_kept", rdata, 32'h8765F0A1);
        do_acc(1'b0, 32'h10, 32'h0, 4'b1111);
        chk("sb11_readback", rdata, 32'h8765CCA1);

        do_acc(1'b1, 32'h14, 32'hDEADBEEF, 4'b0111);
        chk("sw14_we_at", we_at, 1);
        chk("sw14_n_re", n_re, 0);
        chk("sw14_done_at", done_at, 2);
        chk("sw14_wdata", wd_at_we, 32'hDEADBEEF);
        do_acc(1'b1, 32'h16, 32'h00001234, 4'b0011);
        chk("sh16_done_at", done_at, 4);
        do_acc(1'b0, 32'h14, 32'h0, 4'b1111);
        chk("sh16_readback", rdata, 32'h1234BEEF);

        do_acc(1'b0, 32'h12, 32'h0, 4'b1111);
        chk("elw_done_at", done_at, 1);
        chk("elw_err", 32'(err_at_done), 1);
        chk("elw_strobes", n_re + n_we, 0);
        chk("elw_rdata", rdata, 32'h1234BEEF);
        do_acc(1'b0, 32'h11, 32'h0, 4'b1011);
        chk("elh_done_at", done_at, 1);
        chk("elh_err", 32'(err_at_done), 1);
        chk("elh_strobes", n_re + n_we, 0);
        do_acc(1'b0, 32'h10, 32'h0, 4'b0101);
        chk("emask_done_at", done_at, 1);
        chk("emask_err", 32'(err_at_done), 1);
        chk("emask_strobes", n_re + n_we, 0);
        chk("emask_rdata", rdata, 32'h1234BEEF);

        // Held request: second load waits for the done cycle of the first.
        req = 1'b1; we = 1'b0; addr = 32'h10; sign_mask = 4'b1111;
        @(posedge clk);
        #1 addr = 32'h13; sign_mask = 4'b0001;
        done_bits = '0; re_bits = '0; rdy_bits = '0; rd_k3 = '0; rd_k6 = '0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            done_bits[k] = done;
            re_bits[k]   = mem_re;
            rdy_bits[k]  = ready;
            if (k == 3) rd_k3 = rdata;
            if (k == 6) rd_k6 = rdata;
            if (k == 4) req = 1'b0;
        end
        chk("busy_done_bits", 32'(done_bits), 32'h48);
        chk("busy_re_bits", 32'(re_bits), 32'h12);
        chk("busy_ready_k12", 32'(rdy_bits[2:1]), 0);
        chk("busy_ready_k3", 32'(rdy_bits[3]), 1);
        chk("busy_rd_first", rd_k3, 32'h8765CCA1);
        chk("busy_rd_second", rd_k6, 32'h00000087);

        preset = 1'b1;
        @(negedge clk);
        preset = 1'b0;
        req = 1'b1; we = 1'b1; addr = 32'h11; wdata = 32'h000000CC; sign_mask = 4'b0001;
        @(posedge clk);
        #1 req = 1'b0;
        n_we = 0;
        @(negedge clk);
        chk("rmid_re_t1", 32'(mem_re), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rmid_done", 32'(done), 0);
        chk("rmid_err", 32'(err), 0);
        chk("rmid_rdata", rdata, 0);
        chk("rmid_mem_re", 32'(mem_re), 0);
        chk("rmid_mem_we", 32'(mem_we), 0);
        chk("rmid_mem_addr", 32'(mem_addr), 0);
        chk("rmid_mem_wdata", mem_wdata, 0);
        chk("rmid_ready", 32'(ready), 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (mem_we || done) n_we++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (mem_we || done) n_we++;
        end
        chk("rmid_no_we_done", n_we, 0);
        chk("rmid_mem_word", mem[4], 32'h8765F0A1);

        chk("re_we_overlap", both_cnt, 0);
        chk("err_without_done", err_nodone_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
